// File: rtl/sec_pc.sv
// Secure program counter: checked jumps, sequential step, violation lockout.
// Optional SEC_PC_TRAP_EN: a rejected jump redirects pc to TRAP_VEC.
module sec_pc #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000,
    parameter int unsigned VIOL_MAX = 3,
    parameter logic [63:0] TRAP_VEC = 64'h0000_0000_0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jmp_valid,
    input  logic [63:0] jmp_tgt,
    output logic        jmp_ready,
    input  logic        step,
    input  logic        unlock,
    output logic [63:0] pc,
    output logic        fault,
    output logic        locked,
    output logic [7:0]  viol_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic        fault_q;
    logic        locked_q;
    logic [7:0]  viol_q;
    logic [7:0]  viol_d;

    logic accept;
    logic tgt_ok;
    logic lock_hit;

    assign jmp_ready = (state_q == RUN) & ~rst;
    assign accept    = jmp_valid & jmp_ready;
    assign tgt_ok    = (jmp_tgt != 64'd0) && (jmp_tgt[1:0] == 2'b00);

    // Saturating increment; lock as soon as the new count reaches the limit.
    assign viol_d   = (viol_q == 8'hFF) ? viol_q : viol_q + 8'd1;
    assign lock_hit = (32'(viol_d) >= VIOL_MAX);

`ifndef SEC_PC_TRAP_EN
    logic unused_trap;
    assign unused_trap = ^TRAP_VEC;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            locked_q <= 1'b0;
            viol_q   <= 8'd0;
        end else begin
            fault_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (accept) begin
                        if (tgt_ok) begin
                            pc_q <= jmp_tgt;
                        end else begin
                            fault_q <= 1'b1;
                            viol_q  <= viol_d;
`ifdef SEC_PC_TRAP_EN
                            pc_q    <= TRAP_VEC;
`endif
                            if (lock_hit) begin
                                state_q  <= LOCK;
                                locked_q <= 1'b1;
                            end
                        end
                    end else if (step) begin
                        pc_q <= pc_q + 64'd4;
                    end
                end
                LOCK: begin
                    if (unlock) begin
                        state_q  <= RUN;
                        locked_q <= 1'b0;
                        viol_q   <= 8'd0;
                    end
                end
            endcase
        end
    end

    assign pc       = pc_q;
    assign fault    = fault_q;
    assign locked   = locked_q;
    assign viol_cnt = viol_q;

endmodule

// File: tb/tb_sec_pc.sv
// Bench for sec_pc: directed scenarios then random traffic,
// all outputs compared against a behavioural model each cycle.
module tb_sec_pc;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam logic [63:0] TRAP   = 64'h100;
    localparam int          VMAX   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        jmp_valid;
    logic [63:0] jmp_tgt;
    logic        jmp_ready;
    logic        step;
    logic        unlock;
    logic [63:0] pc;
    logic        fault;
    logic        locked;
    logic [7:0]  viol_cnt;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model state
    logic [63:0] m_pc;
    logic        m_lock;
    int          m_cnt;
    logic        m_fault;

    sec_pc #(
        .RESET_PC(RST_PC),
        .VIOL_MAX(VMAX),
        .TRAP_VEC(TRAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .jmp_valid(jmp_valid),
        .jmp_tgt  (jmp_tgt),
        .jmp_ready(jmp_ready),
        .step     (step),
        .unlock   (unlock),
        .pc       (pc),
        .fault    (fault),
        .locked   (locked),
        .viol_cnt (viol_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model(input logic v, input logic [63:0] t,
                         input logic s, input logic u, input logic r);
        if (r) begin
            m_pc = RST_PC; m_lock = 0; m_cnt = 0; m_fault = 0;
        end else if (m_lock) begin
            m_fault = 0;
            if (u) begin
                m_lock = 0; m_cnt = 0;
            end
        end else if (v) begin
            if (t != 0 && t % 4 == 0) begin
                m_pc = t; m_fault = 0;
            end else begin
                m_fault = 1;
                m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                if (m_cnt >= VMAX) m_lock = 1;
`ifdef SEC_PC_TRAP_EN
                m_pc = TRAP;
`endif
            end
        end else begin
            m_fault = 0;
            if (s) m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic cyc(input logic v, input logic [63:0] t,
                       input logic s, input logic u, input logic r);
        @(negedge clk);
        jmp_valid = v; jmp_tgt = t; step = s; unlock = u; rst = r;
        #1;
        check("jmp_ready", 64'(jmp_ready), 64'(!m_lock && !r));
        model(v, t, s, u, r);
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("fault", 64'(fault), 64'(m_fault));
        check("locked", 64'(locked), 64'(m_lock));
        check("viol_cnt", 64'(viol_cnt), 64'(m_cnt));
    endtask

    function automatic logic [63:0] rnd_tgt();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom % 5)
            0: return 64'd0;
            1: return r & ~64'd3;
            2: return (r & ~64'd3) | 64'($urandom_range(1, 3));
            3: return 64'hFFFF_FFFF_FFFF_FFFC;
            default: return 64'h2000 + 64'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        rst = 1; jmp_valid = 0; jmp_tgt = 0; step = 0; unlock = 0;
        m_pc = 'x; m_lock = 0; m_cnt = 0; m_fault = 0;

        cyc(1, 64'h4000, 1, 0, 1);
        check("reset_pc", pc, 64'h1000);
        repeat (3) cyc(0, 0, 1, 0, 0);
        check("step3", pc, 64'h100C);

        cyc(1, 64'hA219_9870, 1, 0, 0);
        check("jump_over_step", pc, 64'hA219_9870);

        cyc(0, 0, 0, 0, 1);
        cyc(1, 64'd0, 0, 0, 0);
        check("viol1_cnt", 64'(viol_cnt), 64'd1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 64'hA219_9872, 1, 0, 0);
        check("viol2_cnt", 64'(viol_cnt), 64'd2);
        cyc(1, 64'h3, 0, 0, 0);
        check("viol3_lock", 64'(locked), 64'd1);
        cyc(1, 64'h8000, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("unlock_cnt", 64'(viol_cnt), 64'd0);
        cyc(0, 0, 0, 1, 0);

        cyc(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("wrap", pc, 64'd0);

        repeat (3) cyc(1, 64'd1, 0, 0, 0);
        cyc(1, 64'h40, 1, 0, 1);
        check("rst_in_lock", pc, 64'h1000);

        for (int i = 0; i < 400; i++) begin
            cyc($urandom % 3 == 0, rnd_tgt(), $urandom % 2 == 0,
                $urandom % 6 == 0, $urandom % 50 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not finish, got running expected done");
        $fatal(1);
    end

endmodule
